// File: rtl/uart_rx_param_if.sv
// Consumer-side bundle of the UART receiver: received word, valid/ready handshake,
// sticky error flags and their clear strobe.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 brk;
  logic                 err_clr;

  modport master (
    output data, valid, frame_err, parity_err, overrun, brk,
    input  ready, err_clr
  );

  modport slave (
    input  data, valid, frame_err, parity_err, overrun, brk,
    output ready, err_clr
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with 3-sample majority vote, false-start
// rejection, sticky error flags and a valid/ready output handshake.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk_50m,
  input  logic           rst,
  input  logic           clken,
  input  logic           rx,
  uart_rx_param_if.master bus
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] VOTE_A   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] VOTE_B   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] VOTE_C   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] BIT_END  = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  state_t               state_next;
  logic                 rx_meta;
  logic                 rx_s;
  logic [SW-1:0]        sample;
  logic [IW-1:0]        idx;
  logic                 stop_cnt;
  logic                 vote_a;
  logic                 vote_b;
  logic [DATA_BITS-1:0] scratch;
  logic                 par_bit;
  logic                 par_bad;
  logic                 stop_bad;
  logic                 armed;
  logic                 majority;
  logic                 at_vote;
  logic                 at_end;
  logic                 last_stop;
  logic                 complete;
  logic                 fe_now;
  logic                 brk_now;

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign majority  = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
  assign at_vote   = clken && (sample == VOTE_C);
  assign at_end    = clken && (sample == BIT_END);
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign complete  = (state == STOP) && at_vote && last_stop;
  assign fe_now    = stop_bad | ~majority;
  assign brk_now   = (scratch == '0) && ((PARITY == 0) || !par_bit) && fe_now;

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (clken && !rx_s && armed) state_next = START;
      START: begin
        if (at_vote && majority) state_next = IDLE;
        else if (at_end)         state_next = DATA;
      end
      DATA:  if (at_end && idx == LAST_IDX) state_next = (PARITY != 0) ? PAR : STOP;
      PAR:   if (at_end) state_next = STOP;
      STOP:  if (complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // After a frame whose final stop bit was low, the line must be seen high before
  // another start is accepted, so a held break produces a single word.
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      sample   <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      vote_a   <= 1'b1;
      vote_b   <= 1'b1;
      scratch  <= '0;
      par_bit  <= 1'b0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
      armed    <= 1'b1;
    end else if (clken) begin
      if (state == IDLE) begin
        sample   <= (!rx_s && armed) ? SW'(1) : '0;
        idx      <= '0;
        stop_cnt <= 1'b0;
        par_bit  <= 1'b0;
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
        if (rx_s) armed <= 1'b1;
      end else begin
        if (sample == VOTE_A) vote_a <= rx_s;
        if (sample == VOTE_B) vote_b <= rx_s;
        if (state_next == IDLE || sample == BIT_END) sample <= '0;
        else                                         sample <= sample + SW'(1);
        if (state == DATA && sample == VOTE_C) scratch[idx] <= majority;
        if (state == DATA && sample == BIT_END && idx != LAST_IDX) idx <= idx + IW'(1);
        if (state == PAR && sample == VOTE_C) begin
          par_bit <= majority;
          par_bad <= majority != ((PARITY == 1) ? ~(^scratch) : (^scratch));
        end
        if (state == STOP && sample == VOTE_C) begin
          if (!majority) stop_bad <= 1'b1;
          if (last_stop && !majority) armed <= 1'b0;
        end
        if (state == STOP && sample == BIT_END) stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

  // A completion while a word is still pending drops the new frame, unless the
  // consumer takes the old word in that very cycle.
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      bus.data       <= '0;
      bus.valid      <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.brk        <= 1'b0;
    end else begin
      if (complete && (!bus.valid || bus.ready)) begin
        bus.data  <= scratch;
        bus.valid <= 1'b1;
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end
      bus.frame_err  <= (bus.frame_err  & ~bus.err_clr) | (complete & fe_now);
      bus.parity_err <= (bus.parity_err & ~bus.err_clr) | (complete & par_bad);
      bus.brk        <= (bus.brk        & ~bus.err_clr) | (complete & brk_now);
      bus.overrun    <= (bus.overrun    & ~bus.err_clr) | (complete & bus.valid & ~bus.ready);
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three instances (8N1, 8E1, 7N2 at 8x) share
// clock, reset and clken; each frame's expected word and flags are queued when sent.
module tb_uart_rx_param;
  logic       clk_50m = 1'b0;
  logic       rst     = 1'b0;
  logic       clken   = 1'b0;
  logic [2:0] rx_l    = 3'b111;
  logic [2:0] rdy     = 3'b000;
  logic [2:0] clr     = 3'b000;

  always #5 clk_50m = ~clk_50m;
  always @(posedge clk_50m) clken <= ~clken;

  uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_param_if #(.DATA_BITS(8)) bus_b ();
  uart_rx_param_if #(.DATA_BITS(7)) bus_c ();

  assign bus_a.ready = rdy[0];
  assign bus_b.ready = rdy[1];
  assign bus_c.ready = rdy[2];
  assign bus_a.err_clr = clr[0];
  assign bus_b.err_clr = clr[1];
  assign bus_c.err_clr = clr[2];

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk_50m(clk_50m), .rst(rst), .clken(clken), .rx(rx_l[0]), .bus(bus_a));
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk_50m(clk_50m), .rst(rst), .clken(clken), .rx(rx_l[1]), .bus(bus_b));
  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clk_50m(clk_50m), .rst(rst), .clken(clken), .rx(rx_l[2]), .bus(bus_c));

  logic [2:0] valid_v, fe_v, pe_v, ov_v, brk_v;
  logic [8:0] data_v [3];
  assign valid_v   = {bus_c.valid, bus_b.valid, bus_a.valid};
  assign fe_v      = {bus_c.frame_err, bus_b.frame_err, bus_a.frame_err};
  assign pe_v      = {bus_c.parity_err, bus_b.parity_err, bus_a.parity_err};
  assign ov_v      = {bus_c.overrun, bus_b.overrun, bus_a.overrun};
  assign brk_v     = {bus_c.brk, bus_b.brk, bus_a.brk};
  assign data_v[0] = {1'b0, bus_a.data};
  assign data_v[1] = {1'b0, bus_b.data};
  assign data_v[2] = {2'b00, bus_c.data};

  typedef struct {
    logic [8:0] data;
    logic [2:0] flags;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   lat         = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (2 * n) @(negedge clk_50m);
  endtask

  // Every frame starts on the negedge just before a clken posedge so timing repeats exactly.
  task automatic align();
    do @(negedge clk_50m); while (clken !== 1'b1);
  endtask

  task automatic emit(input int unit, input logic val, input int os, input bit glitch);
    for (int t = 0; t < os; t++) begin
      rx_l[unit] = (glitch && t == os / 2) ? ~val : val;
      tick(1);
    end
  endtask

  task automatic applyStimulus(input int unit, input logic [8:0] word, input int nbits,
                               input int os, input int par_mode, input bit par_flip,
                               input int nstop, input logic [1:0] stop_vals,
                               input int glitch_bit, input bit push);
    logic [8:0] w;
    logic       pbit;
    logic       fe;
    exp_t       e;
    w      = word & ((9'd1 << nbits) - 9'd1);
    pbit   = ((par_mode == 1) ? ~(^w) : (^w)) ^ par_flip;
    fe     = (stop_vals[0] == 1'b0) || (nstop == 2 && stop_vals[1] == 1'b0);
    e.data = w;
    e.flags = {(w == 9'd0) && (par_mode == 0 || !pbit) && fe, (par_mode != 0) && par_flip, fe};
    if (push) sb.push_back(e);
    clr[unit] = 1'b1;
    @(negedge clk_50m);
    clr[unit] = 1'b0;
    align();
    emit(unit, 1'b0, os, 1'b0);
    for (int i = 0; i < nbits; i++) emit(unit, w[i], os, i == glitch_bit);
    if (par_mode != 0) emit(unit, pbit, os, 1'b0);
    for (int s = 0; s < nstop; s++) emit(unit, stop_vals[s], os, 1'b0);
    rx_l[unit] = 1'b1;
    tick(2);
  endtask

  task automatic expect_word(input int unit);
    exp_t e;
    int   n;
    n = 0;
    while (valid_v[unit] !== 1'b1 && n < 400) begin
      @(negedge clk_50m);
      n++;
    end
    checkOutput($sformatf("valid_u%0d", unit), 32'(valid_v[unit]), 32'd1);
    checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput($sformatf("data_u%0d", unit), 32'(data_v[unit]), 32'(e.data));
      checkOutput($sformatf("flags_u%0d", unit),
                  32'({brk_v[unit], pe_v[unit], fe_v[unit]}), 32'(e.flags));
    end
  endtask

  task automatic consume(input int unit);
    rdy[unit] = 1'b1;
    @(negedge clk_50m);
    rdy[unit] = 1'b0;
    checkOutput($sformatf("valid_drop_u%0d", unit), 32'(valid_v[unit]), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    repeat (4) @(negedge clk_50m);
    checkOutput("rst_valid", 32'(valid_v), 32'd0);
    checkOutput("rst_data", 32'(data_v[0]), 32'd0);
    checkOutput("rst_flags", 32'({fe_v, pe_v, ov_v, brk_v}), 32'd0);
    rst = 1'b1;
    tick(4);

    // 8N1 basic word and the hold/release handshake
    applyStimulus(0, 9'h0A5, 8, 16, 0, 1'b0, 1, 2'b11, -1, 1'b1);
    expect_word(0);
    checkOutput("overrun_t1", 32'(ov_v[0]), 32'd0);
    tick(30);
    checkOutput("hold_valid", 32'(valid_v[0]), 32'd1);
    checkOutput("hold_data", 32'(data_v[0]), 32'h0A5);
    consume(0);

    // even parity: a good frame, then a wrong parity bit
    applyStimulus(1, 9'h007, 8, 16, 2, 1'b0, 1, 2'b11, -1, 1'b1);
    expect_word(1);
    consume(1);
    applyStimulus(1, 9'h003, 8, 16, 2, 1'b1, 1, 2'b11, -1, 1'b1);
    expect_word(1);
    consume(1);
    clr[1] = 1'b1;
    @(negedge clk_50m);
    clr[1] = 1'b0;
    checkOutput("parity_clr", 32'(pe_v[1]), 32'd0);

    // short low pulse is a false start
    align();
    rx_l[0] = 1'b0;
    tick(5);
    rx_l[0] = 1'b1;
    tick(40);
    checkOutput("false_start_valid", 32'(valid_v[0]), 32'd0);
    checkOutput("false_start_flags", 32'({fe_v[0], brk_v[0]}), 32'd0);
    applyStimulus(0, 9'h05A, 8, 16, 0, 1'b0, 1, 2'b11, -1, 1'b1);
    expect_word(0);
    consume(0);

    // overrun, measuring completion timing from frame start
    applyStimulus(0, 9'h011, 8, 16, 0, 1'b0, 1, 2'b11, -1, 1'b1);
    fork
      applyStimulus(0, 9'h022, 8, 16, 0, 1'b0, 1, 2'b11, -1, 1'b0);
      begin
        @(negedge clk_50m);
        align();
        for (int n = 1; n <= 2000; n++) begin
          @(negedge clk_50m);
          if (ov_v[0] === 1'b1) begin
            lat = n;
            break;
          end
        end
      end
    join
    checkOutput("overrun_set", 32'(ov_v[0]), 32'd1);
    expect_word(0);
    consume(0);

    // ready lands exactly on the second completion: new word, no overrun
    applyStimulus(0, 9'h011, 8, 16, 0, 1'b0, 1, 2'b11, -1, 1'b1);
    expect_word(0);
    fork
      applyStimulus(0, 9'h022, 8, 16, 0, 1'b0, 1, 2'b11, -1, 1'b1);
      begin
        @(negedge clk_50m);
        align();
        repeat (lat - 1) @(negedge clk_50m);
        rdy[0] = 1'b1;
        @(negedge clk_50m);
        rdy[0] = 1'b0;
        checkOutput("coincide_valid", 32'(valid_v[0]), 32'd1);
        checkOutput("coincide_overrun", 32'(ov_v[0]), 32'd0);
      end
    join
    expect_word(0);
    consume(0);

    // held break: one word only
    clr[0] = 1'b1;
    @(negedge clk_50m);
    clr[0] = 1'b0;
    sb.push_back('{data: 9'h000, flags: 3'b101});
    align();
    rx_l[0] = 1'b0;
    tick(12 * 16);
    expect_word(0);
    consume(0);
    tick(8 * 16);
    checkOutput("brk_no_second", 32'(valid_v[0]), 32'd0);
    rx_l[0] = 1'b1;
    tick(3 * 16);
    checkOutput("brk_idle_high", 32'(valid_v[0]), 32'd0);

    // 7 data bits, 2 stop bits, 8x: glitch, bad second stop, reset mid-frame
    applyStimulus(2, 9'h055, 7, 8, 0, 1'b0, 2, 2'b11, 3, 1'b1);
    expect_word(2);
    consume(2);
    applyStimulus(2, 9'h02A, 7, 8, 0, 1'b0, 2, 2'b01, -1, 1'b1);
    expect_word(2);
    consume(2);
    align();
    rx_l[2] = 1'b0;
    tick(8 * 3);
    rst = 1'b0;
    repeat (2) @(negedge clk_50m);
    checkOutput("midrst_valid", 32'(valid_v), 32'd0);
    checkOutput("midrst_data", 32'(data_v[2]), 32'd0);
    checkOutput("midrst_flags", 32'({fe_v, pe_v, ov_v, brk_v}), 32'd0);
    rx_l[2] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(16);
    applyStimulus(2, 9'h03C, 7, 8, 0, 1'b0, 2, 2'b11, -1, 1'b1);
    expect_word(2);
    consume(2);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
